uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised serial receiver for the meter's data link. It oversamples `rx` at the board clock and deframes words of configurable width, bit order and parity. Good words go into an internal FIFO, drained through a valid/ready handshake by the level/VGA logic. It succeeds the fixed 8-bit receiver by adding parity, error reporting, break handling, buffering and back-pressure.

## Interface
- `board_freq`, 64: clock frequency in ticks per time unit.
- `baud_rate`, 1: bit rate. T = board_freq/baud_rate cycles per bit; T must be an integer ≥ 4. H = T/2, rounded down.
- `data_width`, 8: data bits per frame (5..16).
- `msb_first`, 1: 1 = first data bit received is the MSB; 0 = LSB first.
- `parity_mode`, 0: 0 = none, 1 = even, 2 = odd. The parity bit follows the data bits.
- `depth`, 4: FIFO entries, power of 2, ≥ 2.
- `clk_board` input 1: the only clock; all logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `enable` input 1: receiver enable. The FIFO stays readable when low.
- `rx` input 1: asynchronous serial line, idle high.
- `data` output data_width: FIFO head word.
- `valid` output 1: FIFO not empty.
- `ready` input 1: consumer accepts the head word. A pop occurs when `valid & ready`.
- `frame_err` output 1: one-cycle pulse when the stop bit samples low.
- `parity_err` output 1: one-cycle pulse when the parity check fails.
- `overrun` output 1: one-cycle pulse when a good word is dropped because the FIFO is full.
- `busy` output 1: receiver is not in IDLE.
- `count` output $clog2(depth+1): number of FIFO entries.

## Operation
- `rx` passes through a 2-flop synchroniser, giving `rx_s`. All decisions use `rx_s`.
- Receiver states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - **IDLE:** when `enable` and `rx_s`=0, go to START and load the bit timer.
  - **START:** after H cycles, sample `rx_s`. If 1 (glitch), go to IDLE with no pulse. If 0, go to DATA.
  - **DATA:** sample every T cycles, data_width samples. Shift in MSB-first or LSB-first according to `msb_first`.
  - After the last data bit, go to PARITY if parity_mode≠0, else to STOP.
  - **PARITY:** sample after T cycles. The error condition is XOR(data, parity bit) ≠ (parity_mode==2).
  - **STOP:** sample after T cycles.
    - `rx_s`=0: pulse `frame_err`, discard the word, go to BREAK.
    - `rx_s`=1 with a parity error: pulse `parity_err`, discard the word, go to IDLE.
    - `rx_s`=1 with good parity: push the word, or pulse `overrun` if the FIFO is full and no pop happens this cycle. Go to IDLE.
  - **BREAK:** wait for `rx_s`=1, then go to IDLE. No further frames are detected until then.
- `enable` low in any state forces IDLE on the next edge. A partial word is discarded silently and there are no pulses.
- `frame_err` takes priority: `parity_err` is not pulsed on a framing failure.
- FIFO behaviour:
  - Circular buffer. `data` is registered from the head.
  - Push and pop in the same cycle when full: both occur and `count` is unchanged.
  - A pop when empty is impossible because `valid` is 0.
- Reset: state IDLE and FIFO empty. The synchroniser flops are reset to 1. All outputs are 0: `data`, `valid`, `count`, `busy`, `frame_err`, `parity_err`, `overrun`.

## Timing
- Let E be the `clk_board` edge on which `rx_s` first reads 0 in IDLE. `busy` is high from E+1.
- Start sample: E+H. Data bit k (k=0..data_width-1) sample: E+H+(k+1)·T. Parity sample: E+H+(data_width+1)·T.
- Stop sample S: E+H+(data_width+1+P)·T, where P=1 if parity is enabled.
- The push occurs at S. `valid`, `data` and `count` update at S+1.
- Error pulses are high for the single cycle S+1.
- `busy` falls at S+1, unless the next state is BREAK.
- A new start may be detected at S+1.
- Pop: when `valid & ready` at edge N, the next entry (or `valid`=0) appears at N+1.

## Test plan
- **Two frames, MSB first.** Defaults (T=64), bits 1,0,1,0,1,0,1,0 then 0,1,0,1,0,1,0,1, `ready`=0. Required: `count` = 2. First pop gives 0xAA, second gives 0x55; `valid` falls after the second pop.
- **LSB first with even parity.** `msb_first`=0, parity_mode=1, bits 1,0,1,0,1,0,1,0 (0x55 received LSB first) with parity bit 0. Required: 0x55 is pushed. Repeat with parity bit 1: required `parity_err` single pulse and no push.
- **Break.** Stop bit low and `rx` held low for 5 bit times. Required: `frame_err` single pulse, no push, `busy` high until 2–3 cycles after `rx` rises, and the next frame is received correctly.
- **Overrun.** depth=2, `ready`=0, three good frames 0x11, 0x22, 0x33. Required: `overrun` pulse on the third frame, FIFO holds 0x11 then 0x22. Also assert `ready` on the same edge as the third push: required no overrun and FIFO holds 0x22, 0x33.
- **Glitch rejection.** `rx` low for H/2 cycles. Required: return to IDLE, no pulses, `count` unchanged.
- **Reset and enable abort.** Assert `reset_n`=0 mid-DATA with 1 entry queued. Required: all outputs 0 immediately. Separately, drop `enable` mid-frame: required `busy` falls next cycle and no push or pulse occurs.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Word stream leaving the UART receiver FIFO: master drives data/valid, slave returns ready.
// A transfer happens on any clock edge where valid & ready are both high.
interface uart_rx_fifo_if #(
  parameter int data_width = 8
);
  logic [data_width-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (parity, framing/break detection) feeding a circular FIFO.
// Word reaches the FIFO head one cycle after the stop sample; ready drains it, a full FIFO drops words with overrun.
module uart_rx_fifo #(
  parameter int board_freq  = 64,
  parameter int baud_rate   = 1,
  parameter int data_width  = 8,
  parameter int msb_first   = 1,
  parameter int parity_mode = 0,
  parameter int depth       = 4
) (
  input  logic                       clk_board,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       rx,
  uart_rx_fifo_if.master             rx_out,
  output logic                       frame_err,
  output logic                       parity_err,
  output logic                       overrun,
  output logic                       busy,
  output logic [$clog2(depth+1)-1:0] count
);
  localparam int T  = board_freq / baud_rate;
  localparam int H  = T / 2;
  localparam int TW = $clog2(T);
  localparam int BW = $clog2(data_width);
  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth + 1);

  localparam logic [TW-1:0] T_LOAD   = TW'(T - 1);
  localparam logic [TW-1:0] H_LOAD   = TW'(H - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(data_width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t                state, state_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic [data_width-1:0] shreg, shreg_nxt;
  logic                  par_bad, par_bad_nxt;
  logic                  tick;
  logic                  push_req, frame_nxt, parity_nxt;
  logic                  rx_meta, rx_s;

  logic [data_width-1:0] mem [depth];
  logic [AW-1:0]         wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]         count_q, count_nxt;
  logic [data_width-1:0] data_q, data_nxt;
  logic                  pop, full, do_push;

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk_board or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (timer == '0);
  assign busy = (state != IDLE);

  always_ff @(posedge clk_board or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    bit_nxt     = bit_cnt;
    shreg_nxt   = shreg;
    par_bad_nxt = par_bad;
    push_req    = 1'b0;
    frame_nxt   = 1'b0;
    parity_nxt  = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt   = START;
            timer_nxt   = H_LOAD;
            par_bad_nxt = 1'b0;
          end
        end
        START: begin
          if (!tick) begin
            timer_nxt = timer - 1'b1;
          end else if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            timer_nxt = T_LOAD;
            bit_nxt   = '0;
          end
        end
        DATA: begin
          if (!tick) begin
            timer_nxt = timer - 1'b1;
          end else begin
            if (msb_first != 0) shreg_nxt = {shreg[data_width-2:0], rx_s};
            else                shreg_nxt = {rx_s, shreg[data_width-1:1]};
            timer_nxt = T_LOAD;
            if (bit_cnt == LAST_BIT) state_nxt = (parity_mode != 0) ? PARITY : STOP;
            else                     bit_nxt   = bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (!tick) begin
            timer_nxt = timer - 1'b1;
          end else begin
            par_bad_nxt = ((^shreg) ^ rx_s) != (parity_mode == 2);
            state_nxt   = STOP;
            timer_nxt   = T_LOAD;
          end
        end
        STOP: begin
          if (!tick) begin
            timer_nxt = timer - 1'b1;
          end else if (!rx_s) begin
            frame_nxt = 1'b1;
            state_nxt = BREAK;
          end else begin
            parity_nxt = par_bad;
            push_req   = !par_bad;
            state_nxt  = IDLE;
          end
        end
        BREAK: begin
          if (rx_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_board or negedge reset_n) begin
    if (!reset_n) begin
      timer      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      timer      <= timer_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      par_bad    <= par_bad_nxt;
      frame_err  <= frame_nxt;
      parity_err <= parity_nxt;
      overrun    <= push_req & full & ~pop;
    end
  end

  // A full FIFO still accepts the word when the head leaves on the same edge.
  assign pop     = rx_out.valid & rx_out.ready;
  assign full    = (count_q == CW'(depth));
  assign do_push = push_req & (~full | pop);
  assign rd_nxt  = rd_ptr + AW'(pop);

  always_comb begin
    count_nxt = count_q;
    if (do_push && !pop)      count_nxt = count_q + CW'(1);
    else if (!do_push && pop) count_nxt = count_q - CW'(1);
  end

  // The head register bypasses memory when the pushed word becomes the head.
  always_comb begin
    data_nxt = mem[rd_nxt];
    if (count_nxt == '0)          data_nxt = '0;
    else if (count_q == CW'(pop)) data_nxt = shreg;
  end

  always_ff @(posedge clk_board) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_board or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_nxt;
      count_q <= count_nxt;
      data_q  <= data_nxt;
    end
  end

  assign rx_out.data  = data_q;
  assign rx_out.valid = (count_q != '0);
  assign count        = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized frames on two receiver configurations, checked against a queue model.
module tb_uart_rx_fifo;
  localparam int T       = 64;
  localparam int H       = T / 2;
  localparam int SOFF_A  = 3 + H + 9 * T;
  localparam int SOFF_B  = 3 + H + 10 * T;
  localparam int DEPTH_A = 4;
  localparam int DEPTH_B = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] en_v, rx_v, rdy_v, busy_v, ferr_v, perr_v, ovr_v;
  logic [2:0] cnt_a;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_pass   = 0;
  int nferr[2]    = '{0, 0};
  int nperr[2]    = '{0, 0};
  int novr[2]     = '{0, 0};
  int exp_ferr[2] = '{0, 0};
  int exp_perr[2] = '{0, 0};
  int exp_ovr[2]  = '{0, 0};
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  uart_rx_fifo_if #(.data_width(8)) if_a ();
  uart_rx_fifo_if #(.data_width(8)) if_b ();
  assign if_a.ready = rdy_v[0];
  assign if_b.ready = rdy_v[1];

  uart_rx_fifo u_a (
    .clk_board(clk), .reset_n(reset_n), .enable(en_v[0]), .rx(rx_v[0]), .rx_out(if_a),
    .frame_err(ferr_v[0]), .parity_err(perr_v[0]), .overrun(ovr_v[0]), .busy(busy_v[0]), .count(cnt_a)
  );

  uart_rx_fifo #(.msb_first(0), .parity_mode(1), .depth(DEPTH_B)) u_b (
    .clk_board(clk), .reset_n(reset_n), .enable(en_v[1]), .rx(rx_v[1]), .rx_out(if_b),
    .frame_err(ferr_v[1]), .parity_err(perr_v[1]), .overrun(ovr_v[1]), .busy(busy_v[1]), .count(cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ferr_v[i]) nferr[i]++;
      if (perr_v[i]) nperr[i]++;
      if (ovr_v[i])  novr[i]++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] dut_data(input int d);
    return (d == 0) ? if_a.data : if_b.data;
  endfunction
  function automatic logic dut_valid(input int d);
    return (d == 0) ? if_a.valid : if_b.valid;
  endfunction
  function automatic int dut_count(input int d);
    return (d == 0) ? 32'(cnt_a) : 32'(cnt_b);
  endfunction
  function automatic int q_size(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction
  function automatic logic [7:0] q_head(input int d);
    return (d == 0) ? qa[0] : qb[0];
  endfunction

  task automatic q_pop(input int d);
    logic [7:0] tmp;
    if (d == 0) tmp = qa.pop_front();
    else        tmp = qb.pop_front();
  endtask

  // Reference: a good frame lands in the FIFO unless it is full (after any same-edge pop).
  task automatic model_frame(input int d, input logic [7:0] w, input logic par_flip,
                             input logic stop_lvl, input logic pop_first);
    if (!stop_lvl) exp_ferr[d]++;
    else if (par_flip) exp_perr[d]++;
    else begin
      if (pop_first) q_pop(d);
      if (q_size(d) < ((d == 0) ? DEPTH_A : DEPTH_B)) begin
        if (d == 0) qa.push_back(w);
        else        qb.push_back(w);
      end else exp_ovr[d]++;
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic lvl, input int cyc);
    rx_v[d] = lvl;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  // DUT A: MSB first, no parity. DUT B: LSB first, even parity.
  task automatic send_frame(input int d, input logic [7:0] w, input logic par_flip,
                            input logic stop_lvl, input int extra_low);
    drive(d, 1'b0, T);
    for (int k = 0; k < 8; k++) drive(d, (d == 0) ? w[7-k] : w[k], T);
    if (d == 1) drive(d, (^w) ^ par_flip, T);
    drive(d, stop_lvl, T + extra_low);
    rx_v[d] = 1'b1;
  endtask

  task automatic check_state(input int d, input string tag);
    chk({tag, "_busy"}, busy_v[d], 1'b0);
    chk({tag, "_count"}, dut_count(d), q_size(d));
    chk({tag, "_valid"}, dut_valid(d), q_size(d) != 0);
    if (q_size(d) != 0) chk({tag, "_data"}, dut_data(d), q_head(d));
    chk({tag, "_frame_err_pulses"}, nferr[d], exp_ferr[d]);
    chk({tag, "_parity_err_pulses"}, nperr[d], exp_perr[d]);
    chk({tag, "_overrun_pulses"}, novr[d], exp_ovr[d]);
  endtask

  task automatic pop_and_check(input int d, input string tag);
    sync();
    chk({tag, "_valid_before_pop"}, dut_valid(d), 1'b1);
    rdy_v[d] = 1'b1;
    @(posedge clk);
    #1 rdy_v[d] = 1'b0;
    q_pop(d);
    @(negedge clk);
    check_state(d, tag);
  endtask

  initial begin
    logic [7:0] w;
    int         d;
    logic       pf;
    reset_n = 1'b0;
    en_v    = 2'b11;
    rx_v    = 2'b11;
    rdy_v   = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", if_a.data, 8'h00);
    chk("rst_valid", if_a.valid, 1'b0);
    chk("rst_count", cnt_a, 3'd0);
    chk("rst_busy", busy_v, 2'b00);
    chk("rst_pulses", {ferr_v, perr_v, ovr_v}, 6'b0);
    chk("rst_b_valid_count", {if_b.valid, cnt_b}, 3'b0);
    reset_n = 1'b1;
    repeat (4) sync();

    // Two MSB-first frames with exact busy/push timing on the first.
    fork
      send_frame(0, 8'hAA, 1'b0, 1'b1, 0);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk) chk("a1_busy_before_E", busy_v[0], 1'b0);
        @(posedge clk);
        @(negedge clk) chk("a1_busy_after_E", busy_v[0], 1'b1);
        repeat (SOFF_A - 4) @(posedge clk);
        @(negedge clk) chk("a1_valid_before_S", {if_a.valid, cnt_a}, 4'b0_000);
        @(posedge clk);
        @(negedge clk) begin
          chk("a1_valid_count_after_S", {if_a.valid, cnt_a}, 4'b1_001);
          chk("a1_data_after_S", if_a.data, 8'hAA);
          chk("a1_busy_after_S", busy_v[0], 1'b0);
        end
      end
    join
    model_frame(0, 8'hAA, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'h55, 1'b0, 1'b1, 0);
    model_frame(0, 8'h55, 1'b0, 1'b1, 1'b0);
    @(negedge clk) check_state(0, "a2");
    pop_and_check(0, "a_pop1");
    pop_and_check(0, "a_pop2");

    // Break: stop low then line held low for five more bit times.
    sync();
    send_frame(0, 8'hC3, 1'b0, 1'b0, 5 * T);
    model_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) chk("brk_busy_2cyc", busy_v[0], 1'b1);
    @(posedge clk);
    @(negedge clk) check_state(0, "brk_release");
    sync();
    send_frame(0, 8'h3C, 1'b0, 1'b1, 0);
    model_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0);
    @(negedge clk) check_state(0, "after_brk");

    // Glitch shorter than half a bit.
    sync();
    drive(0, 1'b0, H / 2);
    @(negedge clk) chk("glitch_busy", busy_v[0], 1'b1);
    drive(0, 1'b1, H + 10);
    @(negedge clk) check_state(0, "glitch");

    // Enable dropped mid-frame.
    sync();
    fork
      send_frame(0, 8'h0F, 1'b0, 1'b1, 0);
      begin
        repeat (200) @(posedge clk);
        @(negedge clk) chk("abort_busy_before", busy_v[0], 1'b1);
        @(posedge clk);
        #1 en_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk) chk("abort_busy_next", busy_v[0], 1'b0);
      end
    join
    en_v[0] = 1'b1;
    @(negedge clk) check_state(0, "abort");

    // LSB first, even parity: good then bad parity.
    sync();
    send_frame(1, 8'h55, 1'b0, 1'b1, 0);
    model_frame(1, 8'h55, 1'b0, 1'b1, 1'b0);
    @(negedge clk) check_state(1, "b_even");
    pop_and_check(1, "b_even_pop");
    sync();
    send_frame(1, 8'h55, 1'b1, 1'b1, 0);
    model_frame(1, 8'h55, 1'b1, 1'b1, 1'b0);
    @(negedge clk) check_state(1, "b_perr");

    // Overrun on a depth-2 FIFO, then the same with a pop on the push edge.
    for (int i = 1; i <= 3; i++) begin
      w = 8'(i * 17);
      sync();
      send_frame(1, w, 1'b0, 1'b1, 0);
      model_frame(1, w, 1'b0, 1'b1, 1'b0);
    end
    @(negedge clk) check_state(1, "b_ovr");
    pop_and_check(1, "b_ovr_pop1");
    pop_and_check(1, "b_ovr_pop2");
    for (int i = 1; i <= 2; i++) begin
      w = 8'(i * 17);
      sync();
      send_frame(1, w, 1'b0, 1'b1, 0);
      model_frame(1, w, 1'b0, 1'b1, 1'b0);
    end
    sync();
    fork
      send_frame(1, 8'h33, 1'b0, 1'b1, 0);
      begin
        repeat (SOFF_B - 1) @(posedge clk);
        #1 rdy_v[1] = 1'b1;
        @(posedge clk);
        #1 rdy_v[1] = 1'b0;
      end
    join
    model_frame(1, 8'h33, 1'b0, 1'b1, 1'b1);
    @(negedge clk) check_state(1, "b_popush");
    pop_and_check(1, "b_popush_pop1");
    pop_and_check(1, "b_popush_pop2");

    // Randomized frames on either receiver.
    for (int i = 0; i < 8; i++) begin
      d  = int'($urandom_range(0, 1));
      w  = 8'($urandom());
      pf = (d == 1) && ($urandom_range(0, 3) == 0);
      sync();
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
      send_frame(d, w, pf, 1'b1, 0);
      model_frame(d, w, pf, 1'b1, 1'b0);
      @(negedge clk) check_state(d, "rnd");
      if (q_size(d) != 0 && $urandom_range(0, 1) == 1) pop_and_check(d, "rnd_pop");
    end

    // Reset in the middle of a data field with one entry queued.
    while (qa.size() != 0) pop_and_check(0, "drain");
    sync();
    send_frame(0, 8'h96, 1'b0, 1'b1, 0);
    model_frame(0, 8'h96, 1'b0, 1'b1, 1'b0);
    @(negedge clk) check_state(0, "pre_rst");
    sync();
    fork
      send_frame(0, 8'h5A, 1'b0, 1'b1, 0);
      begin
        repeat (300) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_data", if_a.data, 8'h00);
        chk("mid_rst_valid_count", {if_a.valid, cnt_a}, 4'b0);
        chk("mid_rst_busy", busy_v[0], 1'b0);
        chk("mid_rst_pulses", {ferr_v[0], perr_v[0], ovr_v[0]}, 3'b0);
        chk("mid_rst_b_valid", if_b.valid, 1'b0);
      end
    join
    qa.delete();
    qb.delete();
    sync();
    reset_n = 1'b1;
    sync();
    send_frame(0, 8'hE7, 1'b0, 1'b1, 0);
    model_frame(0, 8'hE7, 1'b0, 1'b1, 1'b0);
    @(negedge clk) check_state(0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
